// File: rtl/gray_frame_streamer.sv
// ----------------------------------------------------------------------------
// gray_frame_streamer
//
// Purpose:
//   Turns a valid/ready stream of 8-bit gray pixels into a raster-timed
//   camera-style frame interface (vsync / href / clken / pixel). A five-state
//   FSM walks one frame as VSYNC, VBACK, ACTIVE and VFRONT lines. A horizontal
//   counter paces every line and a vertical counter counts lines inside the
//   current state. Pixels are pulled from the source only during the active
//   part of ACTIVE lines. If the source has nothing to offer, timing carries
//   on regardless: a zero pixel is emitted and a sticky underflow flag is set.
//
// Ports:
//   clk              pixel clock
//   rst              synchronous active-high reset
//   enable           start frames / keep streaming (sampled in IDLE and at
//                    the end of every frame)
//   pix_valid        source pixel available
//   pix_data[7:0]    source gray pixel
//   pix_ready        combinational; a pixel is consumed on pix_ready&pix_valid
//   per_frame_vsync  frame sync, registered (one cycle behind the FSM)
//   per_frame_href   line valid, registered copy of pix_ready
//   per_frame_clken  pixel valid, registered copy of pix_ready
//   per_img_y[7:0]   gray pixel output
//   frame_done       one-cycle pulse after the last VFRONT line ends
//   underflow        sticky; set by any pix_ready cycle without pix_valid
// ----------------------------------------------------------------------------
module gray_frame_streamer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_LEN = 2,
    parameter int V_BACK    = 33,
    parameter int V_FRONT   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic [7:0] per_img_y,
    output logic       frame_done,
    output logic       underflow
);

    // ------------------------------------------------------------------------
    // Geometry and counter sizing
    // ------------------------------------------------------------------------
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LINE_LEN  = H_ACTIVE + H_BLANK;
    localparam int MAX_LINES = max2(max2(VSYNC_LEN, V_BACK), max2(V_ACTIVE, V_FRONT));
    localparam int CNT_MAX   = max2(LINE_LEN, MAX_LINES);
    // One width serves both counters; it holds the larger of the line length
    // and the longest per-state line count.
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] H_LAST     = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VSYNC_LAST = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0] VBACK_LAST = CW'(V_BACK - 1);
    localparam logic [CW-1:0] VACT_LAST  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] VFRNT_LAST = CW'(V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   h_cnt_q, h_cnt_d;
    logic [CW-1:0]   v_cnt_q, v_cnt_d;

    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic            clken_q, clken_d;
    logic [7:0]      y_q, y_d;
    logic            frame_done_q, frame_done_d;
    logic            underflow_q, underflow_d;

    // ------------------------------------------------------------------------
    // Shared timing decodes
    // ------------------------------------------------------------------------
    logic running;      // any state other than IDLE
    logic h_wrap;       // last cycle of the current line
    logic last_line;    // v_cnt sits on the final line of the current state
    logic state_end;    // last cycle of the current state
    logic pix_take;     // pixel consumed this cycle
    logic pix_miss;     // slot offered but the source had nothing

    always_comb begin
        running   = (state_q != ST_IDLE);
        h_wrap    = running && (h_cnt_q == H_LAST);

        last_line = 1'b0;
        unique case (state_q)
            ST_VSYNC:  last_line = (v_cnt_q == VSYNC_LAST);
            ST_VBACK:  last_line = (v_cnt_q == VBACK_LAST);
            ST_ACTIVE: last_line = (v_cnt_q == VACT_LAST);
            ST_VFRONT: last_line = (v_cnt_q == VFRNT_LAST);
            default:   last_line = 1'b0;
        endcase

        state_end = h_wrap && last_line;
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register (plus counters and output flops)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            clken_q      <= 1'b0;
            y_q          <= 8'd0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            clken_q      <= clken_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable)    state_d = ST_VSYNC;
            ST_VSYNC:  if (state_end) state_d = ST_VBACK;
            ST_VBACK:  if (state_end) state_d = ST_ACTIVE;
            ST_ACTIVE: if (state_end) state_d = ST_VFRONT;
            // enable is only looked at here, so dropping it mid-frame lets the
            // current frame run to completion.
            ST_VFRONT: if (state_end) state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (running) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            // v_cnt restarts with every state so each state counts its own lines.
            if (state_end) begin
                v_cnt_d = '0;
            end else if (h_wrap) begin
                v_cnt_d = v_cnt_q + 1'b1;
            end else begin
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        pix_ready = (state_q == ST_ACTIVE) && (h_cnt_q < H_ACT_END);
        pix_take  = pix_ready && pix_valid;
        pix_miss  = pix_ready && !pix_valid;

        vsync_d      = (state_q == ST_VSYNC);
        href_d       = pix_ready;
        clken_d      = pix_ready;
        frame_done_d = (state_q == ST_VFRONT) && state_end;
        underflow_d  = underflow_q | pix_miss;

        // A missing pixel still occupies its slot; it is shown as black so
        // the raster geometry never shifts.
        y_d = y_q;
        if (pix_take) begin
            y_d = pix_data;
        end else if (pix_miss) begin
            y_d = 8'd0;
        end
    end

    assign per_frame_vsync = vsync_q;
    assign per_frame_href  = href_q;
    assign per_frame_clken = clken_q;
    assign per_img_y       = y_q;
    assign frame_done      = frame_done_q;
    assign underflow       = underflow_q;

endmodule
